// File: rtl/reorder_buffer_mw.sv
// Multi-wide reorder buffer: in-order allocate, out-of-order writeback, in-order commit with exception flush.
// Defining ROB_STATS_EN adds saturating commit and full-stall statistics counters.
module reorder_buffer_mw #(
    parameter int ENTRIES    = 256,
    parameter int DISPATCH_W = 2,
    parameter int COMMIT_W   = 2,
    parameter int WB_PORTS   = 3,
    parameter int ADDR_BITS  = 64,
    parameter int AREG_BITS  = 5,
    parameter int PREG_BITS  = 7,
    parameter int IDX_BITS   = $clog2(ENTRIES)
) (
    input  logic                             clk_in,
    input  logic                             rst_N_in,
    input  logic [DISPATCH_W-1:0]            alloc_valid_in,
    input  logic [DISPATCH_W*ADDR_BITS-1:0]  alloc_pc_in,
    input  logic [DISPATCH_W*ADDR_BITS-1:0]  alloc_next_pc_in,
    input  logic [DISPATCH_W*AREG_BITS-1:0]  alloc_dest_in,
    input  logic [DISPATCH_W*PREG_BITS-1:0]  alloc_preg_in,
    output logic                             alloc_ready_out,
    output logic [DISPATCH_W*IDX_BITS-1:0]   alloc_idx_out,
    input  logic [WB_PORTS-1:0]              wb_valid_in,
    input  logic [WB_PORTS*IDX_BITS-1:0]     wb_idx_in,
    input  logic [WB_PORTS*3-1:0]            wb_status_in,
    output logic [COMMIT_W-1:0]              commit_valid_out,
    output logic [COMMIT_W*AREG_BITS-1:0]    commit_dest_out,
    output logic [COMMIT_W*PREG_BITS-1:0]    commit_preg_out,
    output logic [COMMIT_W*ADDR_BITS-1:0]    commit_pc_out,
    output logic                             flush_out,
    output logic [ADDR_BITS-1:0]             flush_pc_out,
    output logic [2:0]                       flush_cause_out,
    output logic [IDX_BITS:0]                count_out
`ifdef ROB_STATS_EN
    ,
    output logic [63:0]                      stat_commits_out,
    output logic [31:0]                      stat_full_stalls_out
`endif
);
    localparam int PTR_W = IDX_BITS + 1;
    localparam logic [2:0] ST_ISSUED = 3'd0;
    localparam logic [2:0] ST_DONE   = 3'd1;

    typedef enum logic [0:0] {RUN = 1'b0, FLUSHING = 1'b1} state_t;

    state_t                 state_r, state_nxt_s;
    logic [PTR_W-1:0]       head_r, tail_r, count_s, free_s;
    logic [PTR_W-1:0]       lead_s, alloc_num_s, commit_num_s;
    logic [IDX_BITS-1:0]    head_idx_s, tail_idx_s;
    logic                   ready_s, flush_s, lead_stop_s, scan_stop_s;
    logic [WB_PORTS-1:0]    wb_ok_s;
    logic [2:0]             status_r [ENTRIES];
    logic [ADDR_BITS-1:0]   pc_r     [ENTRIES];
    logic [AREG_BITS-1:0]   dest_r   [ENTRIES];
    logic [PREG_BITS-1:0]   preg_r   [ENTRIES];
    logic                   unused_s;

    assign unused_s   = ^alloc_next_pc_in;
    assign head_idx_s = head_r[IDX_BITS-1:0];
    assign tail_idx_s = tail_r[IDX_BITS-1:0];
    assign count_s    = tail_r - head_r;
    assign free_s     = PTR_W'(ENTRIES) - count_s;
    assign ready_s    = (state_r == RUN) && (free_s >= PTR_W'(DISPATCH_W));

    assign alloc_ready_out = ready_s;
    assign count_out       = count_s;
    assign flush_out       = flush_s;

    // Leading contiguous valid lanes; a gap ends the dispatch group.
    always_comb begin
        lead_s      = {PTR_W{1'b0}};
        lead_stop_s = 1'b0;
        alloc_idx_out = {(DISPATCH_W*IDX_BITS){1'b0}};
        for (int i = 0; i < DISPATCH_W; i++) begin
            alloc_idx_out[i*IDX_BITS +: IDX_BITS] = tail_idx_s + IDX_BITS'(i);
            if (alloc_valid_in[i] && !lead_stop_s) begin
                lead_s = lead_s + PTR_W'(1);
            end else begin
                lead_stop_s = 1'b1;
            end
        end
        if (ready_s) begin
            alloc_num_s = lead_s;
        end else begin
            alloc_num_s = {PTR_W{1'b0}};
        end
    end

    // Commit window scan from the head; an exceptional entry ends the scan and raises flush.
    always_comb begin
        logic [IDX_BITS-1:0] scan_idx;
        commit_valid_out = {COMMIT_W{1'b0}};
        commit_dest_out  = {(COMMIT_W*AREG_BITS){1'b0}};
        commit_preg_out  = {(COMMIT_W*PREG_BITS){1'b0}};
        commit_pc_out    = {(COMMIT_W*ADDR_BITS){1'b0}};
        flush_s          = 1'b0;
        flush_pc_out     = {ADDR_BITS{1'b0}};
        flush_cause_out  = 3'd0;
        commit_num_s     = {PTR_W{1'b0}};
        scan_stop_s      = 1'b0;
        for (int i = 0; i < COMMIT_W; i++) begin
            scan_idx = head_idx_s + IDX_BITS'(i);
            if (scan_stop_s || (PTR_W'(i) >= count_s)) begin
                scan_stop_s = 1'b1;
            end else if (status_r[scan_idx] == ST_DONE) begin
                commit_valid_out[i]                        = 1'b1;
                commit_dest_out[i*AREG_BITS +: AREG_BITS]  = dest_r[scan_idx];
                commit_preg_out[i*PREG_BITS +: PREG_BITS]  = preg_r[scan_idx];
                commit_pc_out[i*ADDR_BITS +: ADDR_BITS]    = pc_r[scan_idx];
                commit_num_s                               = commit_num_s + PTR_W'(1);
            end else if (status_r[scan_idx] == ST_ISSUED) begin
                scan_stop_s = 1'b1;
            end else begin
                flush_s         = 1'b1;
                flush_pc_out    = pc_r[scan_idx];
                flush_cause_out = status_r[scan_idx];
                scan_stop_s     = 1'b1;
            end
        end
    end

    // Writeback qualification: in-flight target, non-ISSUED status, not during a flush.
    always_comb begin
        logic [IDX_BITS-1:0] wb_off;
        wb_ok_s = {WB_PORTS{1'b0}};
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_off     = wb_idx_in[p*IDX_BITS +: IDX_BITS] - head_idx_s;
            wb_ok_s[p] = wb_valid_in[p] && (wb_status_in[p*3 +: 3] != ST_ISSUED) &&
                         ({1'b0, wb_off} < count_s) && (state_r == RUN) && !flush_s;
        end
    end

    // Next-state logic: a flush holds off dispatch for exactly one cycle.
    always_comb begin
        state_nxt_s = RUN;
        case (state_r)
            RUN: begin
                if (flush_s) begin
                    state_nxt_s = FLUSHING;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSHING: state_nxt_s = RUN;
            default:  state_nxt_s = RUN;
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_r <= RUN;
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            head_r  <= head_r + commit_num_s;
            if (flush_s) begin
                tail_r <= head_r + commit_num_s;
            end else begin
                tail_r <= tail_r + alloc_num_s;
            end
        end
    end

    // Entry status: later writeback ports override earlier ones through assignment order.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int e = 0; e < ENTRIES; e++) begin
                status_r[e] <= ST_ISSUED;
            end
        end else if (flush_s) begin
            for (int e = 0; e < ENTRIES; e++) begin
                status_r[e] <= ST_ISSUED;
            end
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_ok_s[p]) begin
                    status_r[wb_idx_in[p*IDX_BITS +: IDX_BITS]] <= wb_status_in[p*3 +: 3];
                end
            end
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (PTR_W'(i) < alloc_num_s) begin
                    status_r[tail_idx_s + IDX_BITS'(i)] <= ST_ISSUED;
                end
            end
        end
    end

    // Entry payload storage; contents are only observed once the entry is in flight.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (PTR_W'(i) < alloc_num_s) begin
                pc_r[tail_idx_s + IDX_BITS'(i)]   <= alloc_pc_in[i*ADDR_BITS +: ADDR_BITS];
                dest_r[tail_idx_s + IDX_BITS'(i)] <= alloc_dest_in[i*AREG_BITS +: AREG_BITS];
                preg_r[tail_idx_s + IDX_BITS'(i)] <= alloc_preg_in[i*PREG_BITS +: PREG_BITS];
            end
        end
    end

`ifdef ROB_STATS_EN
    logic [63:0] stat_commits_r;
    logic [31:0] stat_full_stalls_r;

    // Saturating statistics counters.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            stat_commits_r     <= 64'd0;
            stat_full_stalls_r <= 32'd0;
        end else begin
            if (stat_commits_r > (64'hFFFF_FFFF_FFFF_FFFF - 64'(commit_num_s))) begin
                stat_commits_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            end else begin
                stat_commits_r <= stat_commits_r + 64'(commit_num_s);
            end
            if (alloc_valid_in[0] && !ready_s && (state_r == RUN) &&
                (stat_full_stalls_r != 32'hFFFF_FFFF)) begin
                stat_full_stalls_r <= stat_full_stalls_r + 32'd1;
            end else begin
                stat_full_stalls_r <= stat_full_stalls_r;
            end
        end
    end

    assign stat_commits_out     = stat_commits_r;
    assign stat_full_stalls_out = stat_full_stalls_r;
`endif
endmodule

// File: doc/reorder_buffer_mw.md
Name: reorder_buffer_mw

Overview:
- Parametrised, multi-wide reorder buffer for the out-of-order backend.
- Dispatch allocates up to DISPATCH_W in-order entries per cycle. Up to WB_PORTS execution writebacks per cycle mark entries DONE or exceptional. Up to COMMIT_W oldest DONE entries retire per cycle to the architectural state/RAT.
- An exceptional head entry triggers a one-shot pipeline flush and empties the buffer.
- Entry status encoding: ISSUED=0, DONE=1, EXCEPTION=2, INTERRUPT=3, TRAP=4.

Parameters:
- ENTRIES, 256, number of entries; power of two, >= DISPATCH_W
- DISPATCH_W, 2, allocation lanes per cycle
- COMMIT_W, 2, commit lanes per cycle
- WB_PORTS, 3, writeback ports
- ADDR_BITS, 64, PC width
- AREG_BITS, 5, architectural register index width
- PREG_BITS, 7, physical register index width
- IDX_BITS, $clog2(ENTRIES), entry index width

Ports:
- clk_in  in  1  clock
- rst_N_in  in  1  reset; one clock, asynchronous assert, active-low
- alloc_valid_in  in  DISPATCH_W  per-lane allocate request; valid lanes contiguous from lane 0
- alloc_pc_in  in  DISPATCH_W*ADDR_BITS  instruction PC per lane
- alloc_next_pc_in  in  DISPATCH_W*ADDR_BITS  predicted next PC per lane
- alloc_dest_in  in  DISPATCH_W*AREG_BITS  architectural destination per lane
- alloc_preg_in  in  DISPATCH_W*PREG_BITS  physical destination per lane
- alloc_ready_out  out  1  buffer accepts the full dispatch group this cycle
- alloc_idx_out  out  DISPATCH_W*IDX_BITS  index assigned per lane (tail+i)
- wb_valid_in  in  WB_PORTS  writeback strobe per port
- wb_idx_in  in  WB_PORTS*IDX_BITS  target entry
- wb_status_in  in  WB_PORTS*3  new status (DONE/EXCEPTION/INTERRUPT/TRAP)
- commit_valid_out  out  COMMIT_W  lane retires this cycle; contiguous from lane 0
- commit_dest_out  out  COMMIT_W*AREG_BITS  retired architectural destination
- commit_preg_out  out  COMMIT_W*PREG_BITS  retired physical destination
- commit_pc_out  out  COMMIT_W*ADDR_BITS  retired PC
- flush_out  out  1  one-cycle flush pulse
- flush_pc_out  out  ADDR_BITS  PC of the faulting entry
- flush_cause_out  out  3  status of the faulting entry
- count_out  out  IDX_BITS+1  current occupancy

Behaviour:
- Pointers: head/tail are IDX_BITS+1 wide (wrap bit). Empty when head==tail. Full when index bits are equal and wrap bits differ. count = tail-head.
- Reset: head=tail=0, all status=ISSUED, state=RUN, count_out=0. All commit and flush outputs are 0. alloc_ready_out=1.
- Reset mid-operation discards all entries; no commit or flush is emitted.
- State machine RUN/FLUSHING:
  - alloc_ready_out = (state==RUN) && (ENTRIES-count >= DISPATCH_W).
  - Free space is computed from start-of-cycle count; same-cycle commits do not count.
- Allocation: all-or-nothing. When alloc_ready_out is high, lane i with alloc_valid_in[i] writes entry tail+i with status ISSUED; tail advances by popcount(alloc_valid_in). Non-contiguous valid lanes: only the leading contiguous lanes are allocated. alloc_idx_out is always driven.
- Writeback: takes effect at the clock edge.
  - A write is ignored if the target is outside [head,tail), if status is ISSUED, or if state is FLUSHING / flush_out is high.
  - Two ports writing the same index: the higher-numbered port wins.
- Commit scan: combinational from registered state. Scan entries head..head+COMMIT_W-1, bounded by count.
  - Consecutive DONE entries assert commit lanes.
  - The scan stops at the first ISSUED entry.
  - If the first non-DONE entry within the window is exceptional at offset k: lanes 0..k-1 commit, and flush_out=1 with that entry's pc and status.
  - head advances by the number committed.
- Latency:
  - Alloc at edge N → writeback accepted from edge N+1 → earliest commit visible in cycle N+2.
  - Writeback at edge N → entry commits in the cycle after N if it is in the window.
- Flush: at the edge where flush_out=1, tail←head (after commit advance), all statuses←ISSUED, state←FLUSHING. FLUSHING lasts one cycle with alloc_ready_out=0, then returns to RUN.
- Wrap-around: indices are taken modulo ENTRIES. Commit and alloc lanes may straddle index ENTRIES-1→0.
- Simultaneous alloc and commit in one cycle are both honoured.

Optional Feature:
- ROB_STATS_EN defined: adds outputs stat_commits_out (64) and stat_full_stalls_out (32), both reset to 0.
  - stat_commits_out adds popcount(commit_valid_out) each cycle.
  - stat_full_stalls_out increments when alloc_valid_in[0]=1, alloc_ready_out=0 and state==RUN. Both saturate.
- Undefined: these ports and their counters do not exist.

Test Plan:
- Reset, then allocate 2 lanes (pc 0x100/0x104) → alloc_idx 0,1; count_out=2. Writeback DONE to both → next cycle commit_valid_out=2'b11, commit_pc 0x100/0x104; count_out=0.
- Out-of-order completion: alloc idx 0..3, writeback DONE idx 3,2,1 → no commit. Then DONE idx 0 → commit 0,1 in that cycle, then 2,3 in the next cycle.
- Exception: idx0 DONE, idx1 EXCEPTION pc 0x200 → commit lane0 only, flush_out=1, flush_pc_out=0x200, cause=2. Next cycle count_out=0, alloc_ready_out=0; the cycle after, alloc_ready_out=1.
- Full: fill 256 entries → alloc_ready_out=0 and count_out=256. With 254 entries, alloc_ready_out=1; commit 2 while allocating 2 → count stays 254.
- Wrap: advance head/tail to 255 → allocation gets idx 255,0. Commit across the boundary in one cycle.
- Async reset asserted mid-flush (between clock edges) → outputs immediately 0, count_out=0, state RUN after deassert.
